// File: rtl/scalar_multiplication.sv
// Elliptic-curve scalar multiply R = k*G over GF(p) by left-to-right
// double-and-add. Point addition and doubling are delegated to multi-cycle
// sub-units. Each sub-unit sits in reset while idle and is released for one
// operation at a time. Field arithmetic lives only inside the sub-units.

// Affine point addition. It also covers P == Q with the tangent slope, and
// P == -Q, which raises infinity. The slope denominator is inverted via
// Fermat: den^(p-2) by square-and-multiply, one exponent bit per cycle.
module point_addition #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  input  logic [n-1:0] x2,
  input  logic [n-1:0] y2,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result_ready,
  output logic         infinity
);
  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {U_SETUP, U_INV, U_LAM, U_X3, U_Y3, U_DONE} ustate_t;

  ustate_t       state, state_next;
  logic [n-1:0]  num, den, r, lam;
  logic [IW-1:0] j;
  logic [n-1:0]  e, sq, sum_y, r_sq;
  logic          same_x, opposite;

  function automatic logic [n-1:0] mod_add(input logic [n-1:0] x, input logic [n-1:0] y,
                                           input logic [n-1:0] m);
    logic [n:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    else s = s;
    return s[n-1:0];
  endfunction

  function automatic logic [n-1:0] mod_sub(input logic [n-1:0] x, input logic [n-1:0] y,
                                           input logic [n-1:0] m);
    logic [n:0] d;
    if (x >= y) d = {1'b0, x} - {1'b0, y};
    else d = {1'b0, x} + {1'b0, m} - {1'b0, y};
    return d[n-1:0];
  endfunction

  function automatic logic [n-1:0] mod_mul(input logic [n-1:0] x, input logic [n-1:0] y,
                                           input logic [n-1:0] m);
    logic [2*n-1:0] pr;
    pr = {{n{1'b0}}, x} * {{n{1'b0}}, y};
    pr = pr % {{n{1'b0}}, m};
    return pr[n-1:0];
  endfunction

  assign e        = p - n'(2);
  assign sq       = mod_mul(x1, x1, p);
  assign sum_y    = mod_add(y1, y2, p);
  assign r_sq     = mod_mul(r, r, p);
  assign same_x   = (x1 == x2);
  assign opposite = same_x && (sum_y == {n{1'b0}});

  // Next-state sequencing of one add/double operation.
  always_comb begin
    state_next = state;
    case (state)
      U_SETUP: if (opposite) state_next = U_DONE; else state_next = U_INV;
      U_INV:   if (j == {IW{1'b0}}) state_next = U_LAM; else state_next = U_INV;
      U_LAM:   state_next = U_X3;
      U_X3:    state_next = U_Y3;
      U_Y3:    state_next = U_DONE;
      U_DONE:  state_next = U_DONE;
      default: state_next = U_SETUP;
    endcase
  end

  // Datapath: slope terms, inversion, then x3 and y3; flags hold until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= U_SETUP;
      num          <= {n{1'b0}};
      den          <= {n{1'b0}};
      r            <= {n{1'b0}};
      lam          <= {n{1'b0}};
      j            <= IW'(n - 1);
      x3           <= {n{1'b0}};
      y3           <= {n{1'b0}};
      result_ready <= 1'b0;
      infinity     <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        U_SETUP: begin
          if (opposite) begin
            infinity <= 1'b1;
          end else if (same_x) begin
            num <= mod_add(mod_add(sq, sq, p), mod_add(sq, a, p), p);
            den <= mod_add(y1, y1, p);
          end else begin
            num <= mod_sub(y2, y1, p);
            den <= mod_sub(x2, x1, p);
          end
          r <= n'(1);
          j <= IW'(n - 1);
        end
        U_INV: begin
          r <= e[j] ? mod_mul(r_sq, den, p) : r_sq;
          if (j != {IW{1'b0}}) j <= j - IW'(1);
        end
        U_LAM: lam <= mod_mul(num, r, p);
        U_X3:  x3 <= mod_sub(mod_sub(mod_mul(lam, lam, p), x1, p), x2, p);
        U_Y3: begin
          y3           <= mod_sub(mod_mul(lam, mod_sub(x1, x3, p), p), y1, p);
          result_ready <= 1'b1;
        end
        default: state <= state_next;
      endcase
    end
  end
endmodule

// Point doubling: the addition core with both operands tied to the same point.
module point_doubling #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] x1,
  input  logic [n-1:0] y1,
  output logic [n-1:0] x3,
  output logic [n-1:0] y3,
  output logic         result_ready,
  output logic         infinity
);
  point_addition #(.n(n)) u_core (
    .clk(clk), .reset(reset), .p(p), .a(a),
    .x1(x1), .y1(y1), .x2(x1), .y2(y1),
    .x3(x3), .y3(y3), .result_ready(result_ready), .infinity(infinity)
  );
endmodule

// Scalar-multiply controller.
module scalar_multiplication #(
  parameter int n = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [n-1:0] p,
  input  logic [n-1:0] a,
  input  logic [n-1:0] k,
  input  logic [n-1:0] xg,
  input  logic [n-1:0] yg,
  output logic [n-1:0] xr,
  output logic [n-1:0] yr,
  output logic         done,
  output logic         infinity,
  output logic         busy
);
  localparam int IW = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [2:0] {IDLE, DBL, DBL_WAIT, CHK, ADD_WAIT, NEXT, DONE} state_t;

  state_t        state, state_next;
  logic [n-1:0]  scalar, base_x, base_y, acc_x, acc_y;
  logic          acc_inf;
  logic [IW-1:0] bit_idx;
  logic [1:0]    wait_phase;
  logic          dbl_reset, add_reset;
  logic [n-1:0]  dbl_x3, dbl_y3, add_x3, add_y3, sub_x3, sub_y3;
  logic          dbl_ready, dbl_inf, add_ready, add_inf, sub_flag, sub_inf;

  point_doubling #(.n(n)) u_dbl (
    .clk(clk), .reset(dbl_reset), .p(p), .a(a), .x1(acc_x), .y1(acc_y),
    .x3(dbl_x3), .y3(dbl_y3), .result_ready(dbl_ready), .infinity(dbl_inf)
  );

  point_addition #(.n(n)) u_add (
    .clk(clk), .reset(add_reset), .p(p), .a(a),
    .x1(acc_x), .y1(acc_y), .x2(base_x), .y2(base_y),
    .x3(add_x3), .y3(add_y3), .result_ready(add_ready), .infinity(add_inf)
  );

  // Only one sub-unit is ever running; select its result by wait state.
  assign sub_x3   = (state == DBL_WAIT) ? dbl_x3 : add_x3;
  assign sub_y3   = (state == DBL_WAIT) ? dbl_y3 : add_y3;
  assign sub_inf  = (state == DBL_WAIT) ? dbl_inf : add_inf;
  assign sub_flag = (state == DBL_WAIT) ? (dbl_ready | dbl_inf) : (add_ready | add_inf);

  // Next-state logic of the double-and-add walk.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = DBL; else state_next = IDLE;
      DBL:      if (acc_inf) state_next = CHK; else state_next = DBL_WAIT;
      DBL_WAIT: if (wait_phase == 2'd2) state_next = CHK; else state_next = DBL_WAIT;
      CHK:      if (!scalar[bit_idx] || acc_inf) state_next = NEXT; else state_next = ADD_WAIT;
      ADD_WAIT: if (wait_phase == 2'd2) state_next = NEXT; else state_next = ADD_WAIT;
      NEXT:     if (bit_idx == {IW{1'b0}}) state_next = DONE; else state_next = DBL;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // State register, accumulator, sub-unit launch/capture and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      scalar     <= {n{1'b0}};
      base_x     <= {n{1'b0}};
      base_y     <= {n{1'b0}};
      acc_x      <= {n{1'b0}};
      acc_y      <= {n{1'b0}};
      acc_inf    <= 1'b1;
      bit_idx    <= {IW{1'b0}};
      wait_phase <= 2'd0;
      dbl_reset  <= 1'b1;
      add_reset  <= 1'b1;
      xr         <= {n{1'b0}};
      yr         <= {n{1'b0}};
      done       <= 1'b0;
      infinity   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state <= state_next;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            scalar   <= k;
            base_x   <= xg;
            base_y   <= yg;
            acc_x    <= {n{1'b0}};
            acc_y    <= {n{1'b0}};
            acc_inf  <= 1'b1;
            bit_idx  <= IW'(n - 1);
            busy     <= 1'b1;
            xr       <= {n{1'b0}};
            yr       <= {n{1'b0}};
            infinity <= 1'b0;
          end
        end
        DBL: begin
          // Launch cycle: the unit is still held in reset, released next edge.
          wait_phase <= 2'd0;
          if (!acc_inf) dbl_reset <= 1'b0;
        end
        DBL_WAIT, ADD_WAIT: begin
          case (wait_phase)
            // Flags in the cycle after launch are stale; skip them.
            2'd0: wait_phase <= 2'd1;
            2'd1: if (sub_flag) wait_phase <= 2'd2;
            default: begin
              acc_x     <= sub_inf ? {n{1'b0}} : sub_x3;
              acc_y     <= sub_inf ? {n{1'b0}} : sub_y3;
              acc_inf   <= sub_inf;
              dbl_reset <= 1'b1;
              add_reset <= 1'b1;
            end
          endcase
        end
        CHK: begin
          wait_phase <= 2'd0;
          if (scalar[bit_idx]) begin
            if (acc_inf) begin
              acc_x   <= base_x;
              acc_y   <= base_y;
              acc_inf <= 1'b0;
            end else begin
              add_reset <= 1'b0;
            end
          end
        end
        NEXT: begin
          if (bit_idx != {IW{1'b0}}) begin
            bit_idx <= bit_idx - IW'(1);
          end else begin
            xr       <= acc_inf ? {n{1'b0}} : acc_x;
            yr       <= acc_inf ? {n{1'b0}} : acc_y;
            infinity <= acc_inf;
            done     <= 1'b1;
          end
        end
        DONE: busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_scalar_multiplication.sv
// Bench for scalar_multiplication on the curve y^2 = x^3 + 2x + 2 over GF(17)
// with base point G = (5,1). The expected results come from a reference model
// that adds G to itself k times with plain integer arithmetic. The scoreboard
// queue pairs expected results with done pulses.
module tb_scalar_multiplication;
  localparam int N  = 10;
  localparam int P  = 17;
  localparam int A  = 2;
  localparam int GX = 5;
  localparam int GY = 1;

  typedef struct packed {
    logic [N-1:0] k;
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         inf;
  } res_t;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] p, a, k, xg, yg, xr, yr;
  logic         done, infinity, busy;

  res_t exp_q[$];
  res_t cur;
  int   total = 0;
  int   bad = 0;
  int   launches = 0;

  scalar_multiplication #(.n(N)) dut (
    .clk(clk), .reset(reset), .start(start), .p(p), .a(a), .k(k),
    .xg(xg), .yg(yg), .xr(xr), .yr(yr), .done(done),
    .infinity(infinity), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int md(int v);
    return ((v % P) + P) % P;
  endfunction

  function automatic int inv(int v);
    for (int t = 1; t < P; t++) if (md(v * t) == 1) return t;
    return 0;
  endfunction

  function automatic res_t ec_add(res_t u, res_t v);
    int x1, y1, x2, y2, lam, x3, y3;
    res_t r;
    if (u.inf) return v;
    if (v.inf) return u;
    x1 = int'(u.x); y1 = int'(u.y); x2 = int'(v.x); y2 = int'(v.y);
    r = '0;
    if (x1 == x2 && md(y1 + y2) == 0) begin
      r.inf = 1'b1;
      return r;
    end
    if (x1 == x2) lam = md((3 * x1 * x1 + A) * inv(md(2 * y1)));
    else lam = md((y2 - y1) * inv(md(x2 - x1)));
    x3 = md(lam * lam - x1 - x2);
    y3 = md(lam * (x1 - x3) - y1);
    r.x = N'(x3);
    r.y = N'(y3);
    return r;
  endfunction

  function automatic res_t model(int kv);
    res_t acc, g;
    acc = '0; acc.inf = 1'b1;
    g = '0; g.x = N'(GX); g.y = N'(GY);
    for (int i = 0; i < kv; i++) acc = ec_add(acc, g);
    acc.k = N'(kv);
    return acc;
  endfunction

  function automatic res_t pt(int kv, int x, int y, bit inf);
    res_t r;
    r.k = N'(kv); r.x = N'(x); r.y = N'(y); r.inf = inf;
    return r;
  endfunction

  task automatic check(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (done) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got (%0d,%0d,inf=%0d), want no done", xr, yr, infinity);
      end else begin
        cur = exp_q.pop_front();
        if ({xr, yr, infinity} !== {cur.x, cur.y, cur.inf}) begin
          bad++;
          $display("FAIL result k=%0d: got (%0d,%0d,inf=%0d), want (%0d,%0d,inf=%0d)",
                   cur.k, xr, yr, infinity, cur.x, cur.y, cur.inf);
        end
      end
    end
  end

  // Count cycles in which either sub-unit is released from reset.
  always @(negedge clk) begin
    if (!dut.dbl_reset || !dut.add_reset) launches++;
  end

  task automatic issue(int kv);
    @(negedge clk);
    k = N'(kv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(string name);
    int c;
    c = 0;
    while (!done && c < 20000) begin
      @(negedge clk);
      c++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout: got no done, want done", name);
    end else begin
      check({name, "_busy_in_done"}, int'(busy), 1);
      @(negedge clk);
      check({name, "_busy_after"}, int'(busy), 0);
    end
  endtask

  task automatic run(int kv, res_t want, string name);
    exp_q.push_back(want);
    issue(kv);
    check({name, "_busy"}, int'(busy), 1);
    wait_done(name);
  endtask

  initial begin
    int c;
    int kv;
    p = N'(P); a = N'(A); xg = N'(GX); yg = N'(GY); k = '0;
    repeat (3) @(negedge clk);
    check("rst_xr", int'(xr), 0);
    check("rst_yr", int'(yr), 0);
    check("rst_done", int'(done), 0);
    check("rst_inf", int'(infinity), 0);
    check("rst_busy", int'(busy), 0);
    reset = 1'b1;
    @(negedge clk);

    run(1,  pt(1, 5, 1, 1'b0),  "k1");
    run(2,  pt(2, 6, 3, 1'b0),  "k2");
    launches = 0;
    run(3,  pt(3, 10, 6, 1'b0), "k3");
    total++;
    if (launches == 0) begin
      bad++;
      $display("FAIL k3_launch: got 0 launch cycles, want >0");
    end
    run(9,  pt(9, 7, 6, 1'b0),  "k9");
    run(18, pt(18, 5, 16, 1'b0), "k18");
    run(20, pt(20, 5, 1, 1'b0), "k20");
    run(19, pt(19, 0, 0, 1'b1), "k19");
    launches = 0;
    run(0,  pt(0, 0, 0, 1'b1),  "k0");
    check("k0_no_launch", launches, 0);

    // A start while busy must be ignored.
    exp_q.push_back(pt(3, 10, 6, 1'b0));
    issue(3);
    repeat (30) @(negedge clk);
    issue(5);
    wait_done("busy_start");
    repeat (5) @(negedge clk);
    check("busy_start_idle", int'(busy), 0);
    run(5, pt(5, 9, 16, 1'b0), "k5");

    // Abort a k=9 job while its final addition is in flight.
    issue(9);
    c = 0;
    while (dut.add_reset && c < 5000) begin
      @(negedge clk);
      c++;
    end
    check("abort_reached_add", int'(dut.add_reset), 0);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_xr", int'(xr), 0);
    check("abort_inf", int'(infinity), 0);
    check("abort_add_reset", int'(dut.add_reset), 1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_idle", int'(busy), 0);
    run(4, pt(4, 3, 1, 1'b0), "k4");

    // Randomized scalars against the reference model.
    for (int i = 0; i < 8; i++) begin
      kv = int'($urandom_range(0, 1023));
      run(kv, model(kv), "rand");
    end

    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scalar_multiplication.md
Name: scalar_multiplication

Overview:
- Computes R = k·G on y^2 = x^3 + a·x + b over GF(p), using left-to-right double-and-add.
- Sits directly upstream of and drives point_addition #(n), which performs every "R + G" step; the block consumes its x3/y3/result_ready/infinity.
- Doublings go to a sibling point_doubling #(n) unit (ports clk, reset, p, a, x1, y1, x3, y3, result_ready, infinity; active-high reset, same launch and flag semantics as point_addition).
- The block is the top-level scalar-multiply stage of the ECC datapath.

Parameters:
- n, 10, bit width of field elements, scalar and prime.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; sampled only in IDLE
- p  input  n  field prime; held stable while busy
- a  input  n  curve coefficient a, forwarded to point_doubling
- k  input  n  scalar, captured on accepted start
- xg  input  n  base point x, captured on accepted start
- yg  input  n  base point y, captured on accepted start
- xr  output  n  result x (valid when done seen and infinity=0)
- yr  output  n  result y
- done  output  1  one-cycle pulse when result valid
- infinity  output  1  result is point at infinity; holds until next accepted start
- busy  output  1  high from accepted start until the done cycle inclusive

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE; xr, yr, done, infinity and busy are 0.
  - Internal accumulator is cleared and its inf flag is set to 1.
  - Both sub-unit resets are held at 1.
- Sub-unit launch:
  - Drive operand registers, assert the sub-unit reset for exactly 1 cycle, then deassert it.
  - Ignore the sub-unit result_ready/infinity in the launch cycle and the following cycle (stale flags).
  - After that, wait for (result_ready | infinity). Capture x3/y3/infinity one cycle after the flag is first seen.
  - Keep the sub-unit reset high while it is idle.
- States:
  - IDLE: busy=0. On start, capture k, xg, yg; set acc_inf=1, bit index i=n-1, busy=1; go to DBL.
  - DBL:
    - If acc_inf=1, skip (2·O=O) and go to CHK.
    - Otherwise launch point_doubling with (acc_x, acc_y) and go to DBL_WAIT.
  - DBL_WAIT: on capture, acc <= (x3, y3); acc_inf <= sub-unit infinity; go to CHK.
  - CHK:
    - If k[i]=0, go to NEXT.
    - If k[i]=1 and acc_inf=1, set acc <= (xg, yg) and acc_inf <= 0 without launching; go to NEXT.
    - Otherwise launch point_addition with x1=acc_x, y1=acc_y, x2=xg, y2=yg; go to ADD_WAIT.
  - ADD_WAIT: on capture, acc <= (x3, y3); acc_inf <= sub-unit infinity; go to NEXT.
  - NEXT: if i=0, go to DONE; else i <= i-1 and go to DBL.
  - DONE: xr <= acc_x, yr <= acc_y, infinity <= acc_inf. Pulse done for 1 cycle, busy=1 in this cycle. Return to IDLE.
- Outputs xr/yr/infinity:
  - Hold their values until the next accepted start.
  - Clear to 0 on that start.
  - When infinity=1, xr and yr are 0.
- Iteration rules: exactly n iterations regardless of leading zeros, so k=0 completes with infinity=1 after n NEXT passes. Latency is data-dependent; there is no fixed cycle count.
- Sequencing: start while busy is ignored, with no effect on the operation in flight. start and done can never coincide in IDLE.
- Widths: all arithmetic is mod p inside the sub-units. This block does no field arithmetic, only registers and muxes.
- Inputs: xg/yg are required to be a valid curve point with values < p. Behaviour for off-curve input is undefined, but the FSM still terminates.
- Reset mid-operation: abort immediately to the reset state. No done pulse is produced; sub-units are forced into reset.

Test Plan:
- Curve for all tests: p=17, a=2, G=(5,1) (group order 19, n=10).
- Basic multiples: start with k=1 -> done, (xr,yr)=(5,1), infinity=0. k=2 -> (6,3). k=3 -> (10,6), which exercises both doubling and addition.
- Larger scalars: k=9 -> (7,6). k=18 -> (5,16). k=20 -> (5,1), confirming wrap through the group order.
- Infinity cases: k=19 -> done with infinity=1, xr=yr=0 (final addition returns infinity). k=0 -> done with infinity=1 and no sub-unit launch observed.
- Start while busy: pulse start with k=5 mid-run of a k=3 job -> single done, result (10,6). A following start with k=5 -> (9,16).
- Reset mid-operation: assert reset=0 during ADD_WAIT of a k=9 job -> outputs 0 and busy=0 within the same cycle, no done pulse. After release, a fresh start with k=4 -> (3,1).
